// File: rtl/dtmf_digit_collector.sv
// DTMF digit debouncer: accepts a key after MIN_ON identical frames, releases after MIN_OFF gap frames,
// and queues each key press in a show-ahead FIFO. Define DTMF_OVERWRITE_EN to overwrite the oldest entry when full.
module dtmf_digit_collector #(
    parameter int MIN_ON  = 3,
    parameter int MIN_OFF = 2,
    parameter int DEPTH   = 8,
    parameter int PTR_W   = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             tone_valid,
    input  logic [15:0]      Tone,
    output logic [3:0]       digit_out,
    output logic             digit_valid,
    input  logic             digit_rd,
    output logic [PTR_W:0]   fifo_count,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic             key_active
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CAND   = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;
    localparam logic [3:0] ON_TH    = MIN_ON[3:0];
    localparam logic [3:0] OFF_TH   = MIN_OFF[3:0];
    localparam bit         ACCEPT_FIRST = (MIN_ON == 1);
`ifdef DTMF_OVERWRITE_EN
    localparam bit         OVERWRITE = 1'b1;
`else
    localparam bit         OVERWRITE = 1'b0;
`endif

    logic           r_tv_d;
    logic [1:0]     r_state;
    logic [3:0]     r_cand;
    logic [3:0]     r_on_cnt;
    logic [3:0]     r_off_cnt;
    logic           r_push_pend;
    logic [3:0]     r_push_data;
    logic [3:0]     r_mem [DEPTH];
    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    logic           r_overflow;

    logic           w_frame;
    logic           w_gap;
    logic [3:0]     w_key;
    logic           w_empty;
    logic           w_full;
    logic           w_pop;
    logic           w_mem_we;
    logic           w_rd_adv;
    logic           w_ovf_event;

    assign w_frame = enable & tone_valid & ~r_tv_d;
    assign w_gap   = |Tone[15:4];
    assign w_key   = Tone[3:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tv_d      <= 1'b0;
            r_state     <= S_IDLE;
            r_cand      <= 4'd0;
            r_on_cnt    <= 4'd0;
            r_off_cnt   <= 4'd0;
            r_push_pend <= 1'b0;
            r_push_data <= 4'd0;
        end else begin
            r_tv_d      <= tone_valid;
            r_push_pend <= 1'b0;
            if (w_frame) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_gap) begin
                            if (ACCEPT_FIRST) begin
                                r_push_pend <= 1'b1;
                                r_push_data <= w_key;
                                r_state     <= S_LOCKED;
                                r_off_cnt   <= 4'd0;
                                r_on_cnt    <= 4'd0;
                            end else begin
                                r_state  <= S_CAND;
                                r_cand   <= w_key;
                                r_on_cnt <= 4'd1;
                            end
                        end
                    end
                    S_CAND: begin
                        if (w_gap) begin
                            r_state  <= S_IDLE;
                            r_on_cnt <= 4'd0;
                        end else if (w_key == r_cand) begin
                            if (r_on_cnt + 4'd1 == ON_TH) begin
                                r_push_pend <= 1'b1;
                                r_push_data <= w_key;
                                r_state     <= S_LOCKED;
                                r_off_cnt   <= 4'd0;
                                r_on_cnt    <= 4'd0;
                            end else begin
                                r_on_cnt <= r_on_cnt + 4'd1;
                            end
                        end else begin
                            r_cand   <= w_key;
                            r_on_cnt <= 4'd1;
                        end
                    end
                    S_LOCKED: begin
                        // Any digit, even a different one, only restarts the release gap.
                        if (w_gap) begin
                            if (r_off_cnt + 4'd1 == OFF_TH) begin
                                r_state   <= S_IDLE;
                                r_off_cnt <= 4'd0;
                            end else begin
                                r_off_cnt <= r_off_cnt + 4'd1;
                            end
                        end else begin
                            r_off_cnt <= 4'd0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                         (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_pop       = digit_rd & ~w_empty;
    assign w_ovf_event = r_push_pend & w_full & ~w_pop;
    assign w_mem_we    = r_push_pend & (~w_full | w_pop | OVERWRITE);
    assign w_rd_adv    = w_pop | (w_ovf_event & OVERWRITE);

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= r_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_mem_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // A fresh loss wins over a simultaneous clear.
            if (w_ovf_event) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign digit_valid = ~w_empty;
    assign digit_out   = w_empty ? 4'd0 : r_mem[r_rd_ptr[PTR_W-1:0]];
    assign fifo_count  = r_wr_ptr - r_rd_ptr;
    assign overflow    = r_overflow;
    assign key_active  = (r_state == S_LOCKED);

endmodule

// File: tb/tb_dtmf_digit_collector.sv
// Scoreboard bench for dtmf_digit_collector: expected digits are queued as presses are driven
// and compared against the FIFO head as it is drained.
module tb_dtmf_digit_collector;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        tone_valid;
    logic [15:0] Tone;
    logic [3:0]  digit_out;
    logic        digit_valid;
    logic        digit_rd;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        ovf_clr;
    logic        key_active;

    int n_checks = 0;
    int n_errors = 0;
    int sb[$];

    dtmf_digit_collector #(.MIN_ON(3), .MIN_OFF(2), .DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .tone_valid(tone_valid),
        .Tone(Tone), .digit_out(digit_out), .digit_valid(digit_valid), .digit_rd(digit_rd),
        .fifo_count(fifo_count), .overflow(overflow), .ovf_clr(ovf_clr), .key_active(key_active)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic frame(input logic [15:0] t);
        Tone = t;
        tone_valid = 1'b1;
        tick;
        tone_valid = 1'b0;
        tick;
    endtask

    task automatic press(input logic [3:0] k);
        for (int i = 0; i < 3; i++) frame({12'd0, k});
        frame(16'd16);
        frame(16'd16);
        sb.push_back(int'(k));
    endtask

    task automatic drain;
        for (int i = 0; i < 12 && digit_valid; i++) begin
            if (sb.size() == 0) check("extra_push", 1, 0);
            else check("head", {28'd0, digit_out}, sb.pop_front());
            digit_rd = 1'b1;
            tick;
            digit_rd = 1'b0;
        end
        check("sb_left", sb.size(), 0);
        check("count_drained", {28'd0, fifo_count}, 0);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; tone_valid = 1'b0; Tone = 16'd16;
        digit_rd = 1'b0; ovf_clr = 1'b0;
        tick; tick;
        check("rst_valid", {31'd0, digit_valid}, 0);
        check("rst_out", {28'd0, digit_out}, 0);
        check("rst_count", {28'd0, fifo_count}, 0);
        check("rst_ovf", {31'd0, overflow}, 0);
        check("rst_key", {31'd0, key_active}, 0);
        reset_n = 1'b1;
        tick;

        // 5,5,5,16,16 with latency and key_active checks
        frame(16'd5); frame(16'd5);
        Tone = 16'd5; tone_valid = 1'b1;
        tick;
        check("t1_valid_at_accept", {31'd0, digit_valid}, 0);
        check("t1_key_on", {31'd0, key_active}, 1);
        tone_valid = 1'b0;
        sb.push_back(5);
        tick;
        check("t1_valid_next", {31'd0, digit_valid}, 1);
        check("t1_head", {28'd0, digit_out}, 5);
        frame(16'd16);
        check("t1_key_gap1", {31'd0, key_active}, 1);
        frame(16'd16);
        check("t1_key_gap2", {31'd0, key_active}, 0);
        drain;

        // 5,5,7,7,7 -> only 7
        frame(16'd5); frame(16'd5);
        frame(16'd7); frame(16'd7); frame(16'd7);
        sb.push_back(7);
        frame(16'd16); frame(16'd16);
        check("t2_count", {28'd0, fifo_count}, 1);
        drain;

        // locked on 9; 9,3,9 no extra push; release with codes above 16
        frame(16'd9); frame(16'd9); frame(16'd9);
        sb.push_back(9);
        frame(16'd9); frame(16'd3); frame(16'd9);
        check("t3_no_repush", {28'd0, fifo_count}, 1);
        check("t3_still_locked", {31'd0, key_active}, 1);
        frame(16'd300); frame(16'hFFFF);
        check("t3_released", {31'd0, key_active}, 0);
        press(4'd9);
        check("t3_count2", {28'd0, fifo_count}, 2);
        drain;

        // fill, then one more press overflows
        for (int k = 1; k <= 8; k++) press(4'(k));
        check("t4_full", {28'd0, fifo_count}, 8);
        check("t4_no_ovf", {31'd0, overflow}, 0);
        press(4'd0);
`ifdef DTMF_OVERWRITE_EN
        void'(sb.pop_front());
`else
        void'(sb.pop_back());
`endif
        check("t4_count", {28'd0, fifo_count}, 8);
        check("t4_ovf", {31'd0, overflow}, 1);
`ifdef DTMF_OVERWRITE_EN
        check("t4_head", {28'd0, digit_out}, 2);
`else
        check("t4_head", {28'd0, digit_out}, 1);
`endif
        ovf_clr = 1'b1; tick; ovf_clr = 1'b0;
        check("t4_ovf_clr", {31'd0, overflow}, 0);
        drain;

        // full, pop coincides with the push landing
        for (int k = 1; k <= 8; k++) press(4'(k));
        frame(16'd0); frame(16'd0);
        Tone = 16'd0; tone_valid = 1'b1;
        tick;
        tone_valid = 1'b0;
        check("t5_head_before", {28'd0, digit_out}, sb.pop_front());
        digit_rd = 1'b1;
        tick;
        digit_rd = 1'b0;
        sb.push_back(0);
        check("t5_count", {28'd0, fifo_count}, 8);
        check("t5_no_ovf", {31'd0, overflow}, 0);
        check("t5_head_after", {28'd0, digit_out}, 2);
        frame(16'd16); frame(16'd16);
        drain;
        digit_rd = 1'b1; tick; digit_rd = 1'b0;
        check("t5_empty_rd_count", {28'd0, fifo_count}, 0);
        check("t5_empty_rd_valid", {31'd0, digit_valid}, 0);

        // held tone_valid is a single frame
        frame(16'd4);
        Tone = 16'd4; tone_valid = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        tone_valid = 1'b0; tick;
        check("t6_held_one_frame", {28'd0, fifo_count}, 0);
        frame(16'd4);
        sb.push_back(4);
        check("t6_third_pushes", {28'd0, fifo_count}, 1);
        frame(16'd16); frame(16'd16);
        drain;

        // enable low ignores frames
        enable = 1'b0;
        for (int i = 0; i < 3; i++) frame(16'd6);
        enable = 1'b1;
        check("t7_disabled", {28'd0, fifo_count}, 0);

        // reset mid-CAND
        frame(16'd4); frame(16'd4);
        reset_n = 1'b0; tick; reset_n = 1'b1;
        check("t8_rst_key", {31'd0, key_active}, 0);
        check("t8_rst_count", {28'd0, fifo_count}, 0);
        frame(16'd4);
        check("t8_no_push", {28'd0, fifo_count}, 0);
        frame(16'd4); frame(16'd4);
        sb.push_back(4);
        frame(16'd16); frame(16'd16);
        drain;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
